// File: rtl/sib_cdc_req_sched.sv
// Round-robin scheduler that shares one toggle-handshake CDC channel among
// NREQ requesters, with an optional acknowledge timeout and a recovery state.
module sib_cdc_req_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_vld,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_gnt,
  output logic [NREQ-1:0]           req_done,
  output logic [NREQ-1:0]           req_err,
  output logic [DW-1:0]             xfer_data,
  output logic                      xfer_tgl,
  input  logic                      ack_tgl_sync,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, WAIT, RECOV} state_t;

  state_t            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [NREQ-1:0]   err_q;
  logic [DW-1:0]     xdata_q;
  logic              tgl_q;
  logic [OW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;

  logic              sel_vld_d;
  logic [OW-1:0]     sel_d;
  logic [DW-1:0]     sel_data_d;
  logic              ack_match;

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin : rr_arb
    logic [OW-1:0] cand;
    sel_vld_d = 1'b0;
    sel_d     = owner_q;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OW'((int'(owner_q) + k) % NREQ);
      if (!sel_vld_d && req_vld[cand]) begin
        sel_vld_d = 1'b1;
        sel_d     = cand;
      end
    end
  end

  always_comb begin : data_mux
    sel_data_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_d == OW'(k)) sel_data_d = req_data[k*DW +: DW];
    end
  end

  // The far side has caught up once its acknowledge toggle equals ours.
  assign ack_match = (ack_tgl_sync == tgl_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      xdata_q <= '0;
      tgl_q   <= 1'b0;
      owner_q <= OW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (sel_vld_d) begin
            gnt_q   <= onehot(sel_d);
            xdata_q <= sel_data_d;
            tgl_q   <= ~tgl_q;
            owner_q <= sel_d;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // An acknowledge in the timeout cycle still counts as success.
          if (ack_match) begin
            done_q  <= onehot(owner_q);
            state_q <= IDLE;
          end else if (TO_EN && (cnt_q == CNT_MAX)) begin
            err_q   <= onehot(owner_q);
            state_q <= RECOV;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RECOV: begin
          if (ack_match) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_gnt   = gnt_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign xfer_data = xdata_q;
  assign xfer_tgl  = tgl_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sib_cdc_req_sched.sv
// Scoreboard bench for sib_cdc_req_sched: one instance with a long timeout,
// one with TIMEOUT=4 for the timeout and collision cases.
module tb_sib_cdc_req_sched;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    vld_a, gnt_a, done_a, err_a;
  logic [NREQ*DW-1:0] data_a;
  logic [DW-1:0]      xd_a;
  logic               tgl_a, ack_a, busy_a;
  logic [1:0]         own_a;

  logic [NREQ-1:0]    vld_b, gnt_b, done_b, err_b;
  logic [NREQ*DW-1:0] data_b;
  logic [DW-1:0]      xd_b;
  logic               tgl_b, ack_b, busy_b;
  logic [1:0]         own_b;

  sib_cdc_req_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .req_vld(vld_a), .req_data(data_a),
    .req_gnt(gnt_a), .req_done(done_a), .req_err(err_a),
    .xfer_data(xd_a), .xfer_tgl(tgl_a), .ack_tgl_sync(ack_a),
    .busy(busy_a), .owner(own_a)
  );

  sib_cdc_req_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .req_vld(vld_b), .req_data(data_b),
    .req_gnt(gnt_b), .req_done(done_b), .req_err(err_b),
    .xfer_data(xd_b), .xfer_tgl(tgl_b), .ack_tgl_sync(ack_b),
    .busy(busy_b), .owner(own_b)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  bit auto_ack_a  = 1'b0;
  bit auto_drop_a = 1'b1;

  localparam logic [3:0] K_GNT = 4'd1, K_DONE = 4'd2, K_ERR = 4'd3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input logic [3:0] kind, input logic [NREQ-1:0] vec,
                                     input logic [DW-1:0] d);
    ev = {20'd0, kind, 8'(vec), d};
  endfunction

  task automatic sb_pop(input bit which, input logic [63:0] obs);
    if (which == 1'b0) begin
      if (q_a.size() == 0) chk("sb_a_unexpected", obs, 64'd0);
      else                 chk("sb_a", obs, q_a.pop_front());
    end else begin
      if (q_b.size() == 0) chk("sb_b_unexpected", obs, 64'd0);
      else                 chk("sb_b", obs, q_b.pop_front());
    end
  endtask

  always @(negedge clk) begin : mon_a
    int np;
    np = int'(|gnt_a) + int'(|done_a) + int'(|err_a);
    if (!rst && np > 0) begin
      chk("excl_a", 64'(np), 64'd1);
      if (|gnt_a)  sb_pop(1'b0, ev(K_GNT, gnt_a, xd_a));
      if (|done_a) sb_pop(1'b0, ev(K_DONE, done_a, '0));
      if (|err_a)  sb_pop(1'b0, ev(K_ERR, err_a, '0));
    end
  end

  always @(negedge clk) begin : mon_b
    int np;
    np = int'(|gnt_b) + int'(|done_b) + int'(|err_b);
    if (!rst && np > 0) begin
      chk("excl_b", 64'(np), 64'd1);
      if (|gnt_b)  sb_pop(1'b1, ev(K_GNT, gnt_b, xd_b));
      if (|done_b) sb_pop(1'b1, ev(K_DONE, done_b, '0));
      if (|err_b)  sb_pop(1'b1, ev(K_ERR, err_b, '0));
    end
  end

  // Advance one cycle; requesters drop on grant and the optional far side acks at once.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop_a) vld_a = vld_a & ~gnt_a;
    vld_b = vld_b & ~gnt_b;
    if (auto_ack_a) ack_a = tgl_a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld_a = '0; vld_b = '0; ack_a = 1'b0; ack_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input bit which);
    int t;
    t = 0;
    while (((which == 1'b0) ? q_a.size() : q_b.size()) != 0 && t < 40) begin
      step();
      t++;
    end
    repeat (3) step();
    chk(which ? "drain_b" : "drain_a", 64'((which == 1'b0) ? q_a.size() : q_b.size()), 64'd0);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int ng;
    int last;
    rst = 1'b1;
    vld_a = '0; vld_b = '0; data_a = '0; data_b = '0; ack_a = 1'b0; ack_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",   64'(gnt_a), 64'd0);
    chk("rst_tgl",   64'(tgl_a), 64'd0);
    chk("rst_data",  64'(xd_a), 64'd0);
    chk("rst_busy",  64'(busy_a), 64'd0);
    chk("rst_owner", 64'(own_a), 64'd3);
    rst = 1'b0;

    // Single transfer straight out of reset, ack six cycles after the toggle.
    vld_a = 4'b0100;
    data_a[2*DW +: DW] = 32'hA5A5_0001;
    q_a.push_back(ev(K_GNT, 4'b0100, 32'hA5A5_0001));
    q_a.push_back(ev(K_DONE, 4'b0100, '0));
    step();
    chk("single_gnt",   64'(gnt_a), 64'b0100);
    chk("single_tgl",   64'(tgl_a), 64'd1);
    chk("single_data",  64'(xd_a), 64'hA5A5_0001);
    chk("single_owner", 64'(own_a), 64'd2);
    chk("single_busy",  64'(busy_a), 64'd1);
    repeat (6) step();
    ack_a = 1'b1;
    chk("single_done_early", 64'(done_a), 64'd0);
    step();
    chk("single_done", 64'(done_a), 64'b0100);
    chk("single_idle", 64'(busy_a), 64'd0);
    drain(1'b0);

    // Fairness: all requesters held high, far side acks immediately.
    do_reset();
    for (int i = 0; i < NREQ; i++) data_a[i*DW +: DW] = 32'h1000_0000 + i;
    for (int r = 0; r < 5; r++) begin
      q_a.push_back(ev(K_GNT, 4'(1 << (r % NREQ)), 32'h1000_0000 + (r % NREQ)));
      q_a.push_back(ev(K_DONE, 4'(1 << (r % NREQ)), '0));
    end
    auto_ack_a = 1'b1;
    auto_drop_a = 1'b0;
    vld_a = 4'hF;
    ng = 0;
    last = 0;
    for (int t = 0; t < 80 && ng < 5; t++) begin
      step();
      if (|gnt_a) begin
        ng++;
        if (ng > 1) chk("fair_gap", 64'(cyc - last), 64'd2);
        last = cyc;
        if (ng == 5) vld_a = '0;
      end
    end
    chk("fair_count", 64'(ng), 64'd5);
    drain(1'b0);
    auto_ack_a = 1'b0;
    auto_drop_a = 1'b1;

    // Withdrawal: requester 1 pulses valid for one cycle while in WAIT.
    vld_a = 4'b0001;
    q_a.push_back(ev(K_GNT, 4'b0001, 32'h1000_0000));
    q_a.push_back(ev(K_DONE, 4'b0001, '0));
    step();
    chk("wd_gnt", 64'(gnt_a), 64'b0001);
    step();
    vld_a[1] = 1'b1;
    step();
    vld_a[1] = 1'b0;
    step();
    ack_a = tgl_a;
    drain(1'b0);

    // Reset three cycles into WAIT aborts the transfer silently.
    vld_a = 4'b1000;
    q_a.push_back(ev(K_GNT, 4'b1000, 32'h1000_0003));
    step();
    chk("rw_gnt", 64'(gnt_a), 64'b1000);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("rw_tgl",   64'(tgl_a), 64'd0);
    chk("rw_busy",  64'(busy_a), 64'd0);
    chk("rw_owner", 64'(own_a), 64'd3);
    vld_a = '0;
    ack_a = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vld_a = 4'b0010;
    q_a.push_back(ev(K_GNT, 4'b0010, 32'h1000_0001));
    q_a.push_back(ev(K_DONE, 4'b0010, '0));
    step();
    chk("rw_new_gnt", 64'(gnt_a), 64'b0010);
    chk("rw_new_tgl", 64'(tgl_a), 64'd1);
    ack_a = 1'b1;
    drain(1'b0);

    // Timeout on the TIMEOUT=4 instance; a request raised in RECOV waits.
    vld_b = 4'b0010;
    data_b[1*DW +: DW] = 32'hBEEF_0001;
    data_b[0*DW +: DW] = 32'hBEEF_0000;
    data_b[2*DW +: DW] = 32'hBEEF_0002;
    q_b.push_back(ev(K_GNT, 4'b0010, 32'hBEEF_0001));
    q_b.push_back(ev(K_ERR, 4'b0010, '0));
    step();
    chk("to_gnt", 64'(gnt_b), 64'b0010);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("to_err_early", 64'(err_b), 64'd0);
    end
    step();
    chk("to_err",  64'(err_b), 64'b0010);
    chk("to_busy", 64'(busy_b), 64'd1);
    vld_b = 4'b0001;
    q_b.push_back(ev(K_GNT, 4'b0001, 32'hBEEF_0000));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("recov_nognt",  64'(gnt_b), 64'd0);
      chk("recov_nodone", 64'(done_b), 64'd0);
    end
    ack_b = tgl_b;
    step();
    chk("recov_exit_nognt", 64'(gnt_b), 64'd0);
    step();
    chk("pend_gnt", 64'(gnt_b), 64'b0001);
    chk("pend_tgl", 64'(tgl_b), 64'd0);
    q_b.push_back(ev(K_DONE, 4'b0001, '0));
    ack_b = tgl_b;
    drain(1'b1);

    // Collision: ack match lands in the cycle the counter reaches TIMEOUT.
    vld_b = 4'b0100;
    q_b.push_back(ev(K_GNT, 4'b0100, 32'hBEEF_0002));
    q_b.push_back(ev(K_DONE, 4'b0100, '0));
    step();
    chk("col_gnt", 64'(gnt_b), 64'b0100);
    repeat (4) step();
    ack_b = tgl_b;
    step();
    chk("col_done", 64'(done_b), 64'b0100);
    chk("col_err",  64'(err_b), 64'd0);
    step();
    chk("col_err_after", 64'(err_b), 64'd0);
    chk("col_idle", 64'(busy_b), 64'd0);
    drain(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
